present_round_ctrl: RTL and testbench
=====================================

PRESENT_ROUND_CTRL -- requirements
Module: present_round_ctrl

Interface
REQ-001 SHALL have parameters: none; data width is `size` (64) from Constants.sv; key width KEY_W is 80, or 128 under PRESENT_KEY128_EN.
REQ-002 SHALL have ports (name  direction  width  meaning):
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  plaintext/key offered
- in_ready  out  1  block can accept
- in_text  in  `size`  plaintext
- in_key  in  KEY_W  cipher key
- out_valid  out  1  ciphertext available
- out_ready  in  1  consumer accepts ciphertext
- out_text  out  `size`  ciphertext
- busy  out  1  encryption in progress (RUN or DONE)
REQ-003 SHALL use one clock; reset SHALL be synchronous and active-high.

Function
REQ-004 SHALL sequence an iterative PRESENT encryption with one round per clock, using the existing permutation layer for the P step.
REQ-005 SHALL implement FSM states IDLE, RUN, DONE.
REQ-006 IDLE: in_ready=1; on in_valid&&in_ready at cycle T, latch state<=in_text, keyreg<=in_key, round<=1, go RUN.
REQ-007 RUN: each cycle state<=P(S(state ^ keyreg[KEY_W-1 -: 64])), keyreg<=key_update(keyreg, round), round<=round+1.
REQ-008 RUN->DONE when round==31 is processed; on that same edge out_text<=P(S(state^K31)) ^ K32, where K32 is the round key derived from the updated keyreg.
REQ-009 out_valid SHALL rise at cycle T+32 (32-cycle latency, accept to valid).
REQ-010 DONE: out_valid=1, out_text stable; the block holds until out_ready=1 (backpressure of unbounded length).
REQ-011 DONE with out_ready=1 -> IDLE next cycle; in_ready SHALL be 0 in RUN and DONE, so no accept can coincide with out handshake.
REQ-012 in_valid during RUN/DONE SHALL be ignored; in_text/in_key need only be stable in the accept cycle.
REQ-013 round counter SHALL be 5 bits, values 1..31, never wraps; the counter value XORed into the key SHALL be the round index before increment.
REQ-014 S-box: 4-bit PRESENT table {C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2} applied to all 16 nibbles.

Reset
REQ-015 rst SHALL force IDLE, in_ready=1, out_valid=0, busy=0, out_text=0, state=0, keyreg=0, round=0.
REQ-016 rst asserted mid-RUN or in DONE SHALL abort the operation; no out_valid follows.

Configuration
REQ-017 Macro PRESENT_KEY128_EN: when defined, KEY_W=128; key update = rotate left 61, S-box on bits [127:124] and [123:120], XOR round into bits [66:62].
REQ-018 When PRESENT_KEY128_EN is undefined, KEY_W=80; key update = rotate left 61, S-box on bits [79:76], XOR round into bits [19:15].

Structure
REQ-019 Package present_pkg SHALL hold the S-box table, FSM state enum, ROUNDS=31 and KEY_W.
REQ-020 Key update SHALL be a separate sub-module present_key_update (combinational, macro-selected width); the permutation layer SHALL be instantiated, not re-coded.

Verification
REQ-021 80-bit: in_text=0, in_key=0 -> out_text=5579C1387B228445, out_valid at T+32.
REQ-022 80-bit: in_text=0, in_key=all ones -> E72C46C0F5945049; in_text=all ones, in_key=0 -> A112FFC72F68417B.
REQ-023 PRESENT_KEY128_EN: in_text=0, in_key=0 -> 96DB702A2E6900AF.
REQ-024 Hold out_ready=0 for 10 cycles after out_valid -> out_text stable, in_ready=0, a second in_valid is ignored; out_ready=1 -> IDLE next cycle, then back-to-back accept works.
REQ-025 rst pulsed at T+15 -> outputs at reset values next cycle, no out_valid; a new request then yields correct ciphertext.
REQ-026 in_text/in_key changed on T+1 after accept -> result unchanged (matches REQ-021 vector).

Source files
------------

// File: rtl/present_pkg.sv
// Shared PRESENT constants, S-box table and FSM state type.
// PRESENT_KEY128_EN selects the 128-bit key schedule; otherwise keys are 80 bits.
package present_pkg;

    localparam int unsigned SIZE   = 64;
    localparam int unsigned ROUNDS = 31;

`ifdef PRESENT_KEY128_EN
    localparam int unsigned KEY_W = 128;
`else
    localparam int unsigned KEY_W = 80;
`endif

    // Nibble x of the table holds S(x); entry 0 sits in the low nibble.
    localparam logic [63:0] SBOX_TABLE = 64'h21748FE3DA09B65C;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    function automatic logic [3:0] sbox4(input logic [3:0] x);
        return SBOX_TABLE[{x, 2'b00} +: 4];
    endfunction

    function automatic logic [SIZE-1:0] sbox_layer(input logic [SIZE-1:0] s);
        logic [SIZE-1:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[4*i +: 4] = sbox4(s[4*i +: 4]);
        end
        return r;
    endfunction

endpackage

// File: rtl/present_key_update.sv
// Combinational PRESENT key-schedule step; width chosen by PRESENT_KEY128_EN.
module present_key_update
    import present_pkg::*;
(
    input  logic [KEY_W-1:0] key_i,
    input  logic [4:0]       round_i,
    output logic [KEY_W-1:0] key_o
);

    logic [KEY_W-1:0] rot;

    always_comb begin
        rot   = {key_i[KEY_W-62:0], key_i[KEY_W-1:KEY_W-61]};
        key_o = rot;
`ifdef PRESENT_KEY128_EN
        key_o[127:124] = sbox4(rot[127:124]);
        key_o[123:120] = sbox4(rot[123:120]);
        key_o[66:62]   = rot[66:62] ^ round_i;
`else
        key_o[79:76] = sbox4(rot[79:76]);
        key_o[19:15] = rot[19:15] ^ round_i;
`endif
    end

endmodule

// File: rtl/present_player.sv
// PRESENT bit permutation: bit i moves to 16*i mod 63, bit 63 stays put.
module present_player
    import present_pkg::*;
(
    input  logic [SIZE-1:0] data_i,
    output logic [SIZE-1:0] data_o
);

    for (genvar i = 0; i < 63; i++) begin : g_perm
        assign data_o[(i * 16) % 63] = data_i[i];
    end
    assign data_o[63] = data_i[63];

endmodule

// File: rtl/present_round_ctrl.sv
// Iterative PRESENT encryptor, one round per clock, valid/ready on both sides.
// PRESENT_KEY128_EN switches the key input and schedule to 128 bits.
module present_round_ctrl
    import present_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SIZE-1:0]  in_text,
    input  logic [KEY_W-1:0] in_key,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SIZE-1:0]  out_text,
    output logic             busy
);

    localparam logic [4:0] LastRound = 5'(ROUNDS);

    state_e           fsm_q, fsm_d;
    logic [SIZE-1:0]  state_q, state_d;
    logic [SIZE-1:0]  out_text_q, out_text_d;
    logic [KEY_W-1:0] key_q, key_d, key_next;
    logic [4:0]       round_q, round_d;
    logic [SIZE-1:0]  sbox_out, perm_out;

    assign sbox_out = sbox_layer(state_q ^ key_q[KEY_W-1 -: SIZE]);

    present_player u_player (
        .data_i (sbox_out),
        .data_o (perm_out)
    );

    present_key_update u_key_update (
        .key_i   (key_q),
        .round_i (round_q),
        .key_o   (key_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q      <= StIdle;
            state_q    <= '0;
            key_q      <= '0;
            round_q    <= '0;
            out_text_q <= '0;
        end else begin
            fsm_q      <= fsm_d;
            state_q    <= state_d;
            key_q      <= key_d;
            round_q    <= round_d;
            out_text_q <= out_text_d;
        end
    end

    always_comb begin
        fsm_d      = fsm_q;
        state_d    = state_q;
        key_d      = key_q;
        round_d    = round_q;
        out_text_d = out_text_q;
        unique case (fsm_q)
            StIdle: begin
                if (in_valid) begin
                    state_d = in_text;
                    key_d   = in_key;
                    round_d = 5'd1;
                    fsm_d   = StRun;
                end
            end
            StRun: begin
                state_d = perm_out;
                key_d   = key_next;
                // Final round folds in K32 from the freshly updated key; counter holds at 31.
                if (round_q == LastRound) begin
                    out_text_d = perm_out ^ key_next[KEY_W-1 -: SIZE];
                    fsm_d      = StDone;
                end else begin
                    round_d = round_q + 5'd1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    fsm_d = StIdle;
                end
            end
            default: fsm_d = StIdle;
        endcase
    end

    assign in_ready  = (fsm_q == StIdle);
    assign out_valid = (fsm_q == StDone);
    assign busy      = (fsm_q != StIdle);
    assign out_text  = out_text_q;

endmodule

// File: tb/tb_present_round_ctrl.sv
// Scoreboard bench for present_round_ctrl: random and known-answer vectors,
// backpressure, mid-run reset abort. Works with or without PRESENT_KEY128_EN.
module tb_present_round_ctrl;
    import present_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [63:0]      in_text;
    logic [KEY_W-1:0] in_key;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_text;
    logic             busy;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [63:0] exp_q[$];
    int          acc_q[$];

    present_round_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_text   (in_text),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_text  (out_text),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    function automatic logic [3:0] ref_s(input logic [3:0] x);
        logic [3:0] t[16];
        t = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
              4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
        return t[x];
    endfunction

    function automatic logic [63:0] ref_slayer(input logic [63:0] s);
        logic [63:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) o[4*i +: 4] = ref_s(s[4*i +: 4]);
        return o;
    endfunction

    function automatic logic [63:0] ref_p(input logic [63:0] s);
        logic [63:0] o;
        o = '0;
        for (int i = 0; i < 63; i++) o[(i * 16) % 63] = s[i];
        o[63] = s[63];
        return o;
    endfunction

    function automatic logic [KEY_W-1:0] ref_key_next(input logic [KEY_W-1:0] k, input int r);
        logic [KEY_W-1:0] n;
        n = (k << 61) | (k >> (KEY_W - 61));
`ifdef PRESENT_KEY128_EN
        n[127:124] = ref_s(n[127:124]);
        n[123:120] = ref_s(n[123:120]);
        n[66:62]   = n[66:62] ^ 5'(r);
`else
        n[79:76] = ref_s(n[79:76]);
        n[19:15] = n[19:15] ^ 5'(r);
`endif
        return n;
    endfunction

    function automatic logic [63:0] ref_encrypt(input logic [63:0] t, input logic [KEY_W-1:0] key);
        logic [63:0]      s;
        logic [KEY_W-1:0] k;
        s = t;
        k = key;
        for (int r = 1; r <= 31; r++) begin
            s = ref_p(ref_slayer(s ^ k[KEY_W-1 -: 64]));
            k = ref_key_next(k, r);
        end
        return s ^ k[KEY_W-1 -: 64];
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [KEY_W-1:0] rand_key();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[KEY_W-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one request; inputs are scrambled right after the accept edge.
    task automatic send(input logic [63:0] t, input logic [KEY_W-1:0] k, input logic [63:0] exp);
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            chk("send_ready_timeout", 64'(in_ready), 64'd1);
            return;
        end
        in_valid = 1'b1;
        in_text  = t;
        in_key   = k;
        exp_q.push_back(exp);
        tick();
        in_valid = 1'b0;
        in_text  = {$urandom, $urandom};
        in_key   = rand_key();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        logic        prev_valid;
        int          a;
        logic [63:0] e;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid = 1'b0;
            end else begin
                if (in_valid && in_ready) acc_q.push_back(cyc);
                if (out_valid && !prev_valid) begin
                    if (acc_q.size() == 0) begin
                        chk("spurious_out_valid", 64'(out_valid), 64'd0);
                    end else begin
                        a = acc_q.pop_front();
                        chk("latency", 64'(cyc - a), 64'd32);
                    end
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_output", out_text, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("ciphertext", out_text, e);
                    end
                end
                prev_valid = out_valid;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    localparam logic [KEY_W-1:0] KEY_ZERO = '0;
    localparam logic [KEY_W-1:0] KEY_ONES = '1;
`ifdef PRESENT_KEY128_EN
    localparam logic [63:0] EXP_ZERO = 64'h96DB702A2E6900AF;
`else
    localparam logic [63:0] EXP_ZERO = 64'h5579C1387B228445;
`endif

    initial begin : stimulus
        logic [63:0]      t, held, e1, e2;
        logic [KEY_W-1:0] k;
        logic             seen;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_text   = '0;
        in_key    = '0;
        out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_out_text", out_text, 64'd0);

        // Known answers
        send(64'd0, KEY_ZERO, EXP_ZERO);
        chk("busy_in_run", 64'(busy), 64'd1);
        chk("in_ready_in_run", 64'(in_ready), 64'd0);
        drain();
`ifdef PRESENT_KEY128_EN
        e1 = ref_encrypt(64'd0, KEY_ONES);
        e2 = ref_encrypt(64'hFFFF_FFFF_FFFF_FFFF, KEY_ZERO);
`else
        e1 = 64'hE72C46C0F5945049;
        e2 = 64'hA112FFC72F68417B;
`endif
        send(64'd0, KEY_ONES, e1);
        drain();
        send(64'hFFFF_FFFF_FFFF_FFFF, KEY_ZERO, e2);
        drain();

        // Random vectors against the model
        for (int i = 0; i < 8; i++) begin
            t = {$urandom, $urandom};
            k = rand_key();
            send(t, k, ref_encrypt(t, k));
        end
        drain();

        // Backpressure: hold out_ready low, poke in_valid while DONE
        out_ready = 1'b0;
        send(64'd0, KEY_ZERO, EXP_ZERO);
        for (int n = 0; n < 100 && !out_valid; n++) tick();
        chk("hold_out_valid", 64'(out_valid), 64'd1);
        held = out_text;
        for (int i = 0; i < 10; i++) begin
            in_valid = (i >= 2 && i <= 4);
            in_text  = {$urandom, $urandom};
            in_key   = rand_key();
            tick();
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_text", out_text, held);
            chk("hold_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("release_idle", 64'(in_ready), 64'd1);
        chk("release_busy", 64'(busy), 64'd0);
        chk("release_queue", 64'(exp_q.size()), 64'd0);
        for (int i = 0; i < 2; i++) begin
            t = {$urandom, $urandom};
            k = rand_key();
            send(t, k, ref_encrypt(t, k));
        end
        drain();

        // Abort with reset at T+15
        t = {$urandom, $urandom};
        k = rand_key();
        send(t, k, ref_encrypt(t, k));
        for (int i = 0; i < 14; i++) tick();
        rst = 1'b1;
        exp_q.delete();
        acc_q.delete();
        tick();
        rst = 1'b0;
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_out_text", out_text, 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        chk("abort_no_valid", 64'(seen), 64'd0);
        send(64'd0, KEY_ZERO, EXP_ZERO);
        drain();

        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
